// File: rtl/iir_biquad_cascade_if.sv
// Sample/coefficient/result bundle for iir_biquad_cascade.
// master: sample source and coef loader; slave: the filter.
interface iir_biquad_cascade_if #(
   parameter int N_BITS     = 32,
   parameter int N_SECTIONS = 2
);
   localparam int CAW = $clog2(5 * N_SECTIONS);

   logic [N_BITS:0] x_i;
   logic            in_valid_i;
   logic            in_ready_o;
   logic            coef_we_i;
   logic [CAW-1:0]  coef_addr_i;
   logic [N_BITS:0] coef_data_i;
   logic            state_clr_i;
   logic [N_BITS:0] y_o;
   logic            out_valid_o;
   logic            sat_o;

   modport master (
      output x_i, in_valid_i,
      output coef_we_i, coef_addr_i, coef_data_i,
      output state_clr_i,
      input  in_ready_o, y_o, out_valid_o, sat_o
   );

   modport slave (
      input  x_i, in_valid_i,
      input  coef_we_i, coef_addr_i, coef_data_i,
      input  state_clr_i,
      output in_ready_o, y_o, out_valid_o, sat_o
   );
endinterface

// File: rtl/iir_biquad_cascade.sv
// Cascade of DF-II biquads on one shared multiply-accumulate unit.
// Ports: clk, rst (async, active high), bus (slave): x/in_valid/
// in_ready sample input, coef_we/addr/data loader, state_clr,
// y/out_valid result pulse, sticky sat flag. Data is sign-magnitude.
module iir_biquad_cascade #(
   parameter int N_BITS     = 32,
   parameter int FRAC_BITS  = 16,
   parameter int N_SECTIONS = 2
) (
   input logic clk,
   input logic rst,
   iir_biquad_cascade_if.slave bus
);
   localparam int OW  = N_BITS + 2;
   localparam int PW  = 2 * N_BITS + 2;
   localparam int AW  = 2 * N_BITS + 5;
   localparam int CAW = $clog2(5 * N_SECTIONS);
   localparam int SW  = (N_SECTIONS > 1) ? $clog2(N_SECTIONS) : 1;

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_FB0  = 4'd1;
   localparam logic [3:0] S_FB1  = 4'd2;
   localparam logic [3:0] S_NRM1 = 4'd3;
   localparam logic [3:0] S_FF0  = 4'd4;
   localparam logic [3:0] S_FF1  = 4'd5;
   localparam logic [3:0] S_FF2  = 4'd6;
   localparam logic [3:0] S_NRM2 = 4'd7;
   localparam logic [3:0] S_DONE = 4'd8;

   typedef logic [N_BITS:0] sm_t;
   typedef logic signed [AW-1:0] acc_t;

   logic [3:0]    state_q, state_d;
   logic [SW-1:0] sec_q, sec_d;
   acc_t          acc_q, acc_d;
   sm_t           u_q, u_d;
   sm_t           w0_q, w0_d;
   sm_t           y_q, y_d;
   logic          out_valid_q, out_valid_d;
   logic          sat_q, sat_d;
   sm_t           coef_q [N_SECTIONS][5];
   sm_t           coef_d [N_SECTIONS][5];
   sm_t           w1_q [N_SECTIONS];
   sm_t           w1_d [N_SECTIONS];
   sm_t           w2_q [N_SECTIONS];
   sm_t           w2_d [N_SECTIONS];

   sm_t                  op_a_sm, op_b_sm;
   logic signed [PW-1:0] prod;
   acc_t                 prod_x, u_x;
   logic [N_BITS+1:0]    rnd;

   // -0 maps to 0 here, so it needs no special case downstream.
   function automatic logic signed [OW-1:0] to_tc(sm_t v);
      logic signed [OW-1:0] m;
      m = $signed({2'b00, v[N_BITS-1:0]});
      return v[N_BITS] ? -m : m;
   endfunction

   // Returns {sat, sign, mag}; sign is dropped when mag rounds to 0.
   function automatic logic [N_BITS+1:0] sat_round(acc_t a);
      logic [AW-1:0] mag;
      logic [AW-1:0] r;
      mag = a[AW-1] ? $unsigned(-a) : $unsigned(a);
      r   = (mag + (AW'(1) << (FRAC_BITS - 1))) >> FRAC_BITS;
      if (|r[AW-1:N_BITS])
         return {1'b1, a[AW-1], {N_BITS{1'b1}}};
      return {1'b0, a[AW-1] & (|r[N_BITS-1:0]), r[N_BITS-1:0]};
   endfunction

   always_comb begin
      op_a_sm = '0;
      op_b_sm = '0;
      case (state_q)
         S_FB0: begin
            op_a_sm = coef_q[sec_q][3];
            op_b_sm = w1_q[sec_q];
         end
         S_FB1: begin
            op_a_sm = coef_q[sec_q][4];
            op_b_sm = w2_q[sec_q];
         end
         S_FF0: begin
            op_a_sm = coef_q[sec_q][0];
            op_b_sm = w0_q;
         end
         S_FF1: begin
            op_a_sm = coef_q[sec_q][1];
            op_b_sm = w1_q[sec_q];
         end
         S_FF2: begin
            op_a_sm = coef_q[sec_q][2];
            op_b_sm = w2_q[sec_q];
         end
         default: ;
      endcase
   end

   assign prod   = PW'(to_tc(op_a_sm)) * PW'(to_tc(op_b_sm));
   assign prod_x = AW'(prod);
   // Section input aligned to the product's 2*FRAC_BITS scale.
   assign u_x    = AW'(to_tc(u_q)) <<< FRAC_BITS;
   assign rnd    = sat_round(acc_q);

   always_comb begin
      state_d     = state_q;
      sec_d       = sec_q;
      acc_d       = acc_q;
      u_d         = u_q;
      w0_d        = w0_q;
      y_d         = y_q;
      out_valid_d = 1'b0;
      sat_d       = sat_q;
      coef_d      = coef_q;
      w1_d        = w1_q;
      w2_d        = w2_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.state_clr_i) begin
               for (int s = 0; s < N_SECTIONS; s++) begin
                  w1_d[s] = '0;
                  w2_d[s] = '0;
               end
               sat_d = 1'b0;
            end else if (bus.in_valid_i) begin
               u_d     = bus.x_i;
               sec_d   = '0;
               state_d = S_FB0;
            end
            if (bus.coef_we_i) begin
               for (int s = 0; s < N_SECTIONS; s++)
                  for (int k = 0; k < 5; k++)
                     if (bus.coef_addr_i == CAW'(5 * s + k))
                        coef_d[s][k] = bus.coef_data_i;
            end
         end
         S_FB0: begin
            acc_d   = u_x - prod_x;
            state_d = S_FB1;
         end
         S_FB1: begin
            acc_d   = acc_q - prod_x;
            state_d = S_NRM1;
         end
         S_NRM1: begin
            w0_d    = rnd[N_BITS:0];
            sat_d   = sat_q | rnd[N_BITS+1];
            state_d = S_FF0;
         end
         S_FF0: begin
            acc_d   = prod_x;
            state_d = S_FF1;
         end
         S_FF1: begin
            acc_d   = acc_q + prod_x;
            state_d = S_FF2;
         end
         S_FF2: begin
            acc_d   = acc_q + prod_x;
            state_d = S_NRM2;
         end
         S_NRM2: begin
            // u doubles as the next section's input.
            u_d         = rnd[N_BITS:0];
            sat_d       = sat_q | rnd[N_BITS+1];
            w2_d[sec_q] = w1_q[sec_q];
            w1_d[sec_q] = w0_q;
            if (sec_q == SW'(N_SECTIONS - 1)) begin
               state_d = S_DONE;
            end else begin
               sec_d   = sec_q + SW'(1);
               state_d = S_FB0;
            end
         end
         S_DONE: begin
            y_d         = u_q;
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sec_q       <= '0;
         acc_q       <= '0;
         u_q         <= '0;
         w0_q        <= '0;
         y_q         <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
         for (int s = 0; s < N_SECTIONS; s++) begin
            w1_q[s] <= '0;
            w2_q[s] <= '0;
            for (int k = 0; k < 5; k++)
               coef_q[s][k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         sec_q       <= sec_d;
         acc_q       <= acc_d;
         u_q         <= u_d;
         w0_q        <= w0_d;
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
         sat_q       <= sat_d;
         coef_q      <= coef_d;
         w1_q        <= w1_d;
         w2_q        <= w2_d;
      end
   end

   assign bus.in_ready_o  = (state_q == S_IDLE);
   assign bus.y_o         = y_q;
   assign bus.out_valid_o = out_valid_q;
   assign bus.sat_o       = sat_q;
endmodule
